// File: rtl/mem_checker_pkg.sv
// Shared definitions for the transfer-path controllers.
// Holds the checker state encoding and the default memory geometry.
package mem_checker_pkg;

  localparam int MC_DATA_WIDTH = 8;
  localparam int MC_ADDR_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    CMP   = 2'd2,
    DONE  = 2'd3
  } mc_state_t;

endpackage

// File: rtl/mem_checker.sv
// mem_checker: walks all 2**ADDR_WIDTH addresses of a ROM (transmitted data)
// and a RAM (received data), compares each pair of words and reports the
// mismatch count and the lowest mismatching address.
//
// Ports
//   clk             single rising-edge clock
//   rst             synchronous active-high reset
//   start           one-cycle request to begin a pass (only honoured in IDLE)
//   rom_addr        ROM read address (same index as ram_addr)
//   rom_data        ROM read data, valid one cycle after rom_addr
//   ram_addr        RAM read address (same index as rom_addr)
//   ram_data        RAM read data, valid one cycle after ram_addr
//   busy            high while words are being fetched/compared
//   done            one-cycle pulse at the end of a pass
//   pass            last completed pass had zero mismatches
//   err_count       mismatching words in the last pass
//   first_err_addr  lowest mismatching address of the last pass
//   first_err_valid first_err_addr holds a captured mismatch
import mem_checker_pkg::*;

module mem_checker #(
  parameter int DATA_WIDTH = MC_DATA_WIDTH,
  parameter int ADDR_WIDTH = MC_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [DATA_WIDTH-1:0] ram_data,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_WIDTH:0]   err_count,
  output logic [ADDR_WIDTH-1:0] first_err_addr,
  output logic                  first_err_valid
);

  mc_state_t             r_state;
  mc_state_t             w_state_next;

  logic [ADDR_WIDTH-1:0] r_idx;
  logic [ADDR_WIDTH:0]   r_err_count;
  logic                  r_pass;
  logic [ADDR_WIDTH-1:0] r_first_err_addr;
  logic                  r_first_err_valid;

  logic                  w_mismatch;
  logic                  w_last;

  assign w_mismatch = (rom_data != ram_data);
  assign w_last     = (r_idx == '1);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and control outputs
  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_next = FETCH;
        end
      end
      FETCH: begin
        busy         = 1'b1;
        w_state_next = CMP;
      end
      CMP: begin
        busy         = 1'b1;
        w_state_next = w_last ? DONE : FETCH;
      end
      DONE: begin
        done         = 1'b1;
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Index counter and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx             <= '0;
      r_err_count       <= '0;
      r_pass            <= 1'b0;
      r_first_err_addr  <= '0;
      r_first_err_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_idx             <= '0;
            r_err_count       <= '0;
            r_pass            <= 1'b0;
            r_first_err_valid <= 1'b0;
          end
        end
        CMP: begin
          if (w_mismatch) begin
            r_err_count <= r_err_count + (ADDR_WIDTH+1)'(1);
            if (!r_first_err_valid) begin
              r_first_err_addr  <= r_idx;
              r_first_err_valid <= 1'b1;
            end
          end
          // The pass flag is registered on the way into DONE so that it
          // already reflects the final word while done is high.
          if (w_last) begin
            r_pass <= (r_err_count == '0) && !w_mismatch;
          end else begin
            r_idx <= r_idx + ADDR_WIDTH'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign rom_addr        = r_idx;
  assign ram_addr        = r_idx;
  assign pass            = r_pass;
  assign err_count       = r_err_count;
  assign first_err_addr  = r_first_err_addr;
  assign first_err_valid = r_first_err_valid;

endmodule

// File: tb/tb_mem_checker.sv
// Scoreboard bench for mem_checker: stimulus pushes the expected pass result,
// a monitor compares it whenever done is presented.
module tb_mem_checker;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int N  = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] rom_addr, ram_addr;
  logic [DW-1:0] rom_q, ram_q;
  logic          busy, done, pass, first_err_valid;
  logic [AW:0]   err_count;
  logic [AW-1:0] first_err_addr;

  logic [DW-1:0] rom [N];
  logic [DW-1:0] ram [N];

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    int          done_cyc;
    logic        pass;
    logic [AW:0] err;
    logic        fev;
    logic [AW-1:0] fea;
  } exp_t;

  exp_t exp_q[$];
  exp_t last_exp;

  mem_checker #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .rom_addr(rom_addr), .rom_data(rom_q),
    .ram_addr(ram_addr), .ram_data(ram_q),
    .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_err_addr(first_err_addr),
    .first_err_valid(first_err_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rom_q <= rom[rom_addr];
    ram_q <= ram[ram_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compare each done pulse against the head of the scoreboard.
  always @(negedge clk) begin
    if (busy) chk("addr_equal", 32'(rom_addr), 32'(ram_addr));
    if (done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no done (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("done_cycle", 32'(cyc), 32'(e.done_cyc));
        chk("busy_in_done", 32'(busy), 32'd0);
        chk("pass", 32'(pass), 32'(e.pass));
        chk("err_count", 32'(err_count), 32'(e.err));
        chk("first_err_valid", 32'(first_err_valid), 32'(e.fev));
        if (e.fev) chk("first_err_addr", 32'(first_err_addr), 32'(e.fea));
      end
    end
  end

  // Start pulse in period s (returned), cleared the next period.
  task automatic pulse_start(output int s);
    @(posedge clk); #1;
    start = 1'b1;
    s = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic expect_pass(input int s, input logic p, input int err,
                             input logic fev, input int fea);
    exp_t e;
    e.done_cyc = s + 2*N + 1;
    e.pass     = p;
    e.err      = (AW+1)'(err);
    e.fev      = fev;
    e.fea      = AW'(fea);
    exp_q.push_back(e);
    last_exp = e;
  endtask

  task automatic wait_done_and_hold;
    int i;
    for (i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done expected done within 100 cycles");
      exp_q.delete();
    end
    repeat (3) @(posedge clk);
    #1;
    chk("hold_pass", 32'(pass), 32'(last_exp.pass));
    chk("hold_err_count", 32'(err_count), 32'(last_exp.err));
    chk("hold_fev", 32'(first_err_valid), 32'(last_exp.fev));
    chk("idle_busy", 32'(busy), 32'd0);
  endtask

  task automatic mem_clean;
    for (int i = 0; i < N; i++) begin
      rom[i] = DW'(i);
      ram[i] = DW'(i);
    end
  endtask

  initial begin
    int s;
    mem_clean();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pass", 32'(pass), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    chk("rst_fea", 32'(first_err_addr), 32'd0);
    chk("rst_fev", 32'(first_err_valid), 32'd0);
    chk("rst_addr", 32'(rom_addr), 32'd0);
    rst = 1'b0;

    // Clean pass
    pulse_start(s);
    expect_pass(s, 1'b1, 0, 1'b0, 0);
    chk("busy_after_start", 32'(busy), 32'd1);
    wait_done_and_hold();

    // Single corruption at word 5
    ram[5] = 8'hFF;
    pulse_start(s);
    expect_pass(s, 1'b0, 1, 1'b1, 5);
    wait_done_and_hold();

    // Last-word mismatch only
    mem_clean();
    ram[15] = 8'h00;
    pulse_start(s);
    expect_pass(s, 1'b0, 1, 1'b1, 15);
    wait_done_and_hold();

    // Every word mismatching
    for (int i = 0; i < N; i++) ram[i] = ~DW'(i);
    pulse_start(s);
    expect_pass(s, 1'b0, 16, 1'b1, 0);
    wait_done_and_hold();

    // Start pulses while busy are ignored (pulse_start ends in period s+1)
    mem_clean();
    ram[5] = 8'hFF;
    pulse_start(s);
    expect_pass(s, 1'b0, 1, 1'b1, 5);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done_and_hold();

    // Reset in cycle 12 of a pass with mismatches accumulating; start held too
    for (int i = 0; i < N; i++) ram[i] = ~DW'(i);
    pulse_start(s);
    repeat (11) @(posedge clk);
    #1;
    chk("midpass_err_nonzero", 32'(err_count != '0), 32'd1);
    rst   = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_done", 32'(done), 32'd0);
    chk("mrst_pass", 32'(pass), 32'd0);
    chk("mrst_err_count", 32'(err_count), 32'd0);
    chk("mrst_fea", 32'(first_err_addr), 32'd0);
    chk("mrst_fev", 32'(first_err_valid), 32'd0);
    chk("mrst_addr", 32'(ram_addr), 32'd0);
    rst   = 1'b0;
    start = 1'b0;
    @(posedge clk); #1;
    chk("rst_over_start_busy", 32'(busy), 32'd0);
    repeat (40) @(posedge clk);

    // Fresh pass after reset
    mem_clean();
    pulse_start(s);
    expect_pass(s, 1'b1, 0, 1'b0, 0);
    wait_done_and_hold();

    // Window for any stray done pulse
    repeat (40) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
